// File: rtl/adc_spi_reader_pkg.sv
// Shared types and frame geometry for the ADC SPI reader.
package adc_spi_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_QUIET
   } state_t;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned LEAD_BITS  = 4;
   localparam int unsigned DATA_W     = 12;

endpackage

// File: rtl/adc_spi_reader_sclk.sv
// SCLK generator: CLK_DIV clk cycles per half-period, idles high while disabled.
module adc_sclk_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   logic [7:0] half_cnt;
   logic       half_done;

   // Strobes flag the clk edge at which the registered sclk will change.
   assign half_done = en && (half_cnt == 8'(CLK_DIV - 1));
   assign rise      = half_done && !sclk;
   assign fall      = half_done && sclk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_cnt <= '0;
         sclk     <= 1'b1;
      end else if (!en) begin
         half_cnt <= '0;
         sclk     <= 1'b1;
      end else if (half_done) begin
         half_cnt <= '0;
         sclk     <= ~sclk;
      end else begin
         half_cnt <= half_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/adc_spi_reader.sv
// Reads one 16-bit frame (4 lead bits + 12 data bits) from a serial ADC per start tick.
module adc_spi_reader
   import adc_spi_reader_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned QUIET   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              sdata,
   output logic              cs_n,
   output logic              sclk,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              frame_err,
   output logic              busy,
   output logic              overrun
);

   state_t                state;
   logic [4:0]            bit_cnt;
   logic [7:0]            quiet_cnt;
   logic [FRAME_BITS-1:0] shift;
   logic                  sclk_en;
   logic                  sclk_rise;
   logic                  sclk_fall;

   assign sclk_en = (state == ST_SETUP) || (state == ST_SHIFT);

   adc_sclk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_sclk_gen (
      .clk (clk),
      .rst (rst),
      .en  (sclk_en),
      .sclk(sclk),
      .rise(sclk_rise),
      .fall(sclk_fall)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         quiet_cnt    <= '0;
         shift        <= '0;
         cs_n         <= 1'b1;
         sample       <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         overrun      <= start && (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_SETUP;
                  cs_n    <= 1'b0;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
               end
            end
            ST_SETUP: begin
               if (sclk_fall) state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               // Complete frame is committed one cycle after the last rising sclk.
               if (bit_cnt == 5'(FRAME_BITS)) begin
                  state        <= ST_QUIET;
                  cs_n         <= 1'b1;
                  quiet_cnt    <= '0;
                  sample_valid <= 1'b1;
                  sample       <= shift[DATA_W-1:0];
                  frame_err    <= |shift[FRAME_BITS-1 -: LEAD_BITS];
               end else if (sclk_rise) begin
                  shift   <= {shift[FRAME_BITS-2:0], sdata};
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end
            ST_QUIET: begin
               if (quiet_cnt == 8'(QUIET - 1)) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  quiet_cnt <= quiet_cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Randomized frame bench for adc_spi_reader with a behavioural ADC and timing model.
module tb_adc_spi_reader;

   localparam int D = 4;
   localparam int Q = 4;
   // Sample-rate tick period scaled down from 29406 to keep the run short.
   localparam int TICK_PERIOD = 294;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic        sdata = 1'b0;
   logic        cs_n;
   logic        sclk;
   logic [11:0] sample;
   logic        sample_valid;
   logic        frame_err;
   logic        busy;
   logic        overrun;

   adc_spi_reader #(
      .CLK_DIV(D),
      .QUIET  (Q)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .sdata       (sdata),
      .cs_n        (cs_n),
      .sclk        (sclk),
      .sample      (sample),
      .sample_valid(sample_valid),
      .frame_err   (frame_err),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   logic [15:0] adc_word = '0;
   int start_cyc = 0;
   int fc = 0;
   int n_cs_fall, cs_fall_at, n_fall, first_fall_at, n_rise, rise16_at;
   int n_valid, valid_at, n_ovr, ovr_at, busy_low_at;
   logic [11:0] got_sample;
   logic        got_err;
   logic p_cs = 1'b1, p_sclk = 1'b1, p_busy = 1'b0;

   task automatic clear_log();
      n_cs_fall = 0; cs_fall_at = -1; n_fall = 0; first_fall_at = -1;
      n_rise = 0; rise16_at = -1; n_valid = 0; valid_at = -1;
      n_ovr = 0; ovr_at = -1; busy_low_at = -1;
      got_sample = '0; got_err = 1'b0;
   endtask

   // Event log plus ADC model: ADC shifts its next bit out after each sclk fall.
   task automatic observe();
      int rel;
      rel = cyc - start_cyc;
      if (p_cs && !cs_n) begin n_cs_fall++; cs_fall_at = rel; end
      if (cs_n) fc = 0;
      else if (p_sclk && !sclk) begin
         fc++; n_fall++;
         if (n_fall == 1) first_fall_at = rel;
      end
      if (!p_sclk && sclk && !cs_n) begin
         n_rise++;
         if (n_rise == 16) rise16_at = rel;
      end
      if (sample_valid === 1'b1) begin
         n_valid++; valid_at = rel; got_sample = sample; got_err = frame_err;
      end
      if (overrun === 1'b1) begin n_ovr++; ovr_at = rel; end
      if (p_busy && !busy) busy_low_at = rel;
      sdata = (fc >= 1 && fc <= 16) ? adc_word[16-fc] : 1'b0;
      p_cs = cs_n; p_sclk = sclk; p_busy = busy;
   endtask

   task automatic tick();
      @(negedge clk);
      observe();
      #1;
   endtask

   task automatic run_to(input int target);
      int guard = 0;
      while ((cyc - start_cyc) < target && guard < 2000) begin tick(); guard++; end
   endtask

   task automatic start_frame(input logic [15:0] w);
      adc_word  = w;
      clear_log();
      start_cyc = cyc;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic check_frame(input logic [15:0] w, input int exp_ovr);
      int guard = 0;
      while (busy_low_at < 0 && guard < 500) begin tick(); guard++; end
      check_eq("frame_done_in_budget", busy_low_at >= 0, 1);
      check_eq("cs_n_low_at", cs_fall_at, 1);
      check_eq("first_sclk_fall_at", first_fall_at, D + 1);
      check_eq("sclk_rises", n_rise, 16);
      check_eq("rise16_at", rise16_at, 32 * D + 1);
      check_eq("valid_count", n_valid, 1);
      check_eq("valid_at", valid_at, 32 * D + 2);
      check_eq("sample", got_sample, {20'd0, w[11:0]});
      check_eq("frame_err", got_err, |w[15:12]);
      check_eq("busy_low_at", busy_low_at, 32 * D + 2 + Q);
      check_eq("overrun_count", n_ovr, exp_ovr);
      check_eq("sample_hold", sample, {20'd0, w[11:0]});
      check_eq("frame_err_hold", frame_err, |w[15:12]);
   endtask

   initial begin
      logic [15:0] w;
      clear_log();
      #1 rst = 1'b1;
      #1;
      check_eq("rst_cs_n", cs_n, 1);
      check_eq("rst_sclk", sclk, 1);
      check_eq("rst_sample", sample, 0);
      check_eq("rst_valid", sample_valid, 0);
      check_eq("rst_frame_err", frame_err, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_overrun", overrun, 0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      start_frame(16'h0A5C);
      check_frame(16'h0A5C, 0);
      start_frame(16'h8FFF);
      check_frame(16'h8FFF, 0);

      for (int i = 0; i < 6; i++) begin
         w = 16'($urandom);
         if ($urandom_range(1) == 0) w[15:12] = 4'h0;
         start_frame(w);
         check_frame(w, 0);
      end

      // start during a frame
      w = 16'($urandom);
      start_frame(w);
      run_to(50);
      start = 1'b1; tick(); start = 1'b0;
      check_frame(w, 1);
      check_eq("overrun_at", ovr_at, 51);
      repeat (30) tick();
      check_eq("no_second_frame", n_cs_fall, 1);

      // reset mid-frame
      w = 16'($urandom) | 16'h0001;
      start_frame(w);
      run_to(60);
      rst = 1'b1;
      #1;
      check_eq("midrst_cs_n", cs_n, 1);
      check_eq("midrst_sclk", sclk, 1);
      check_eq("midrst_busy", busy, 0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (20) tick();
      check_eq("midrst_no_valid", n_valid, 0);
      check_eq("midrst_sample", sample, 0);
      w = 16'($urandom);
      start_frame(w);
      check_frame(w, 0);

      // start in first IDLE cycle is accepted
      w = 16'($urandom);
      start_frame(w);
      run_to(32 * D + 2 + Q);
      check_frame(w, 0);
      w = 16'($urandom);
      start_frame(w);
      check_frame(w, 0);

      // start in the last QUIET cycle is an overrun
      w = 16'($urandom);
      start_frame(w);
      run_to(32 * D + 1 + Q);
      start = 1'b1; tick(); start = 1'b0;
      check_frame(w, 1);
      check_eq("lastq_overrun_at", ovr_at, 32 * D + 2 + Q);
      repeat (30) tick();
      check_eq("lastq_no_frame", n_cs_fall, 1);

      // periodic sample-rate ticks
      clear_log();
      for (int k = 0; k < 5; k++) begin
         adc_word  = 16'($urandom);
         start_cyc = cyc;
         start     = 1'b1;
         tick();
         start     = 1'b0;
         run_to(TICK_PERIOD);
         check_eq("tick_sample", got_sample, {20'd0, adc_word[11:0]});
         check_eq("tick_frame_err", got_err, |adc_word[15:12]);
      end
      check_eq("tick_valid_count", n_valid, 5);
      check_eq("tick_overrun_count", n_ovr, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
